pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_fwd_sel.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding control slice.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 2;
   localparam int unsigned CNT_W = 32;

   // Operand source select driven to the datapath muxes
   localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
   localparam logic [FWD_W-1:0] FWD_MEM  = 2'b01;
   localparam logic [FWD_W-1:0] FWD_WB   = 2'b10;

   // Stall sequencer states; STALLn means n stall cycles owed counting the current one
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL1 = 2'd1,
      STALL2 = 2'd2
   } haz_state_e;

   // True when a writer register matches a source, never for $zero
   function automatic logic reg_hit(input logic [REG_W-1:0] wr, input logic [REG_W-1:0] src);
      return (wr != '0) && (wr == src);
   endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for one operand: MEM result beats WB result, loads in MEM never forward.
module pipe_fwd_sel
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] src_i,
   input  logic [REG_W-1:0] mem_wr_i,
   input  logic             mem_reg_write_i,
   input  logic             mem_mem_read_i,
   input  logic [REG_W-1:0] wb_wr_i,
   input  logic             wb_reg_write_i,
   output logic [FWD_W-1:0] fwd_sel_c_o
);

   // Priority compare, MEM stage first
   always_comb begin
      fwd_sel_c_o = FWD_NONE;
      if (mem_reg_write_i && !mem_mem_read_i && reg_hit(mem_wr_i, src_i)) begin
         fwd_sel_c_o = FWD_MEM;
      end else if (wb_reg_write_i && reg_hit(wb_wr_i, src_i)) begin
         fwd_sel_c_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use / branch stalls, IF/ID flush.
// State updates on the falling CLK edge together with the pipeline registers.
// Optional PIPE_HAZ_PERF_CNT_EN adds saturating stall_cycles / flush_count counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [REG_W-1:0] ID_rs,
   input  logic [REG_W-1:0] ID_rt,
   input  logic             ID_useRs,
   input  logic             ID_useRt,
   input  logic             ID_isBranch,
   input  logic             ID_isJump,
   input  logic             branch_taken,
   input  logic [REG_W-1:0] EX_rs,
   input  logic [REG_W-1:0] EX_rt,
   input  logic [REG_W-1:0] EX_wr,
   input  logic [REG_W-1:0] MEM_wr,
   input  logic [REG_W-1:0] WB_wr,
   input  logic             EX_RegWrite,
   input  logic             EX_MemRead,
   input  logic             MEM_RegWrite,
   input  logic             MEM_MemRead,
   input  logic             WB_RegWrite,
   output logic [FWD_W-1:0] forward_ID_A,
   output logic [FWD_W-1:0] forward_ID_B,
   output logic [FWD_W-1:0] forward_EX_A,
   output logic [FWD_W-1:0] forward_EX_B,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EXE_Flush,
   output logic             stall_busy
`ifdef PIPE_HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
`endif
);

   logic [FWD_W-1:0] fwd_id_a_c, fwd_id_b_c, fwd_ex_a_c, fwd_ex_b_c;
   logic             ex_hit_c, mem_hit_c, haz1_c, haz2_c;
   logic             stall_c, redirect_c;
   haz_state_e       state_q, state_d, cur_c;

   pipe_fwd_sel u_fwd_id_a (
      .src_i(ID_rs), .mem_wr_i(MEM_wr), .mem_reg_write_i(MEM_RegWrite),
      .mem_mem_read_i(MEM_MemRead), .wb_wr_i(WB_wr), .wb_reg_write_i(WB_RegWrite),
      .fwd_sel_c_o(fwd_id_a_c));
   pipe_fwd_sel u_fwd_id_b (
      .src_i(ID_rt), .mem_wr_i(MEM_wr), .mem_reg_write_i(MEM_RegWrite),
      .mem_mem_read_i(MEM_MemRead), .wb_wr_i(WB_wr), .wb_reg_write_i(WB_RegWrite),
      .fwd_sel_c_o(fwd_id_b_c));
   pipe_fwd_sel u_fwd_ex_a (
      .src_i(EX_rs), .mem_wr_i(MEM_wr), .mem_reg_write_i(MEM_RegWrite),
      .mem_mem_read_i(MEM_MemRead), .wb_wr_i(WB_wr), .wb_reg_write_i(WB_RegWrite),
      .fwd_sel_c_o(fwd_ex_a_c));
   pipe_fwd_sel u_fwd_ex_b (
      .src_i(EX_rt), .mem_wr_i(MEM_wr), .mem_reg_write_i(MEM_RegWrite),
      .mem_mem_read_i(MEM_MemRead), .wb_wr_i(WB_wr), .wb_reg_write_i(WB_RegWrite),
      .fwd_sel_c_o(fwd_ex_b_c));

   // Hazard detection against the sources the ID instruction actually reads
   always_comb begin
      ex_hit_c  = (ID_useRs && reg_hit(EX_wr, ID_rs))  || (ID_useRt && reg_hit(EX_wr, ID_rt));
      mem_hit_c = (ID_useRs && reg_hit(MEM_wr, ID_rs)) || (ID_useRt && reg_hit(MEM_wr, ID_rt));
      haz2_c    = ID_isBranch && EX_MemRead && ex_hit_c;
      haz1_c    = (EX_MemRead && ex_hit_c)
               || (ID_isBranch && EX_RegWrite && !EX_MemRead && ex_hit_c)
               || (ID_isBranch && MEM_MemRead && mem_hit_c);
   end

   // Stall sequencer state register
   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Current state enters STALLn in the detection cycle itself, so that cycle is the first stall
   always_comb begin
      cur_c   = state_q;
      state_d = RUN;
      if (state_q == RUN) begin
         if (haz2_c) begin
            cur_c = STALL2;
         end else if (haz1_c) begin
            cur_c = STALL1;
         end
      end
      case (cur_c)
         STALL2:  state_d = STALL1;
         default: state_d = RUN;
      endcase
   end

   // Pipeline control outputs; stall wins over redirect, reset forces a safe flush
   always_comb begin
      stall_c      = (cur_c != RUN);
      redirect_c   = ID_isJump || (ID_isBranch && branch_taken);
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EXE_Flush = 1'b1;
      stall_busy   = 1'b0;
      forward_ID_A = FWD_NONE;
      forward_ID_B = FWD_NONE;
      forward_EX_A = FWD_NONE;
      forward_EX_B = FWD_NONE;
      if (RST_N) begin
         PC_Write     = !stall_c;
         IF_ID_Write  = !stall_c;
         IF_ID_Flush  = !stall_c && redirect_c;
         ID_EXE_Flush = stall_c;
         stall_busy   = stall_c;
         forward_ID_A = fwd_id_a_c;
         forward_ID_B = fwd_id_b_c;
         forward_EX_A = fwd_ex_a_c;
         forward_EX_B = fwd_ex_b_c;
      end
   end

`ifdef PIPE_HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

   // Saturating event counters
   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (stall_busy && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
         end
         if (IF_ID_Flush && (flush_count_q != '1)) begin
            flush_count_q <= flush_count_q + CNT_W'(1);
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule
